apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 142 ++++++++++++++
 tb/tb_apb_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master bridging a valid/ready request port to APB.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       PCLK,
  input  logic       PRST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;
  logic   load;
  logic   done;
  logic   timeout;

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign busy    = (state != IDLE);

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ACCESS exit doubles as an acceptance slot so back-to-back transfers skip IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY || timeout) begin
          done      = 1'b1;
          req_ready = 1'b1;
          if (req_valid) begin
            load      = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      PWRITE <= 1'b0;
      PADDR  <= 8'h00;
      PWDATA <= 8'h00;
    end else if (load) begin
      PWRITE <= req_write;
      PADDR  <= req_addr;
      PWDATA <= req_wdata;
    end
  end

  // PWRITE still describes the finishing transfer here even if a new request loads on this edge.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= done;
      if (done && PREADY && !PWRITE) begin
        rsp_rdata <= PRDATA;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] to_cnt;

  // PREADY wins over the limit, so a completion on the last allowed cycle is a success.
  assign timeout = (state == ACCESS) && !PREADY && (to_cnt == TO_LAST);

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      to_cnt <= 8'h00;
    end else if (state == SETUP) begin
      to_cnt <= 8'h00;
    end else if ((state == ACCESS) && !PREADY) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= timeout;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_timeout = ^TO_LAST;
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master: vector table, corner sequences, random traffic.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRST;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  apb_master #(.TIMEOUT_CYC(4)) dut (
    .PCLK      (PCLK),
    .PRST      (PRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .busy      (busy)
  );

  always #5 PCLK = ~PCLK;

  // Slave with a programmable number of wait states; PRDATA is garbage until PREADY.
  logic [7:0] smem [256] = '{default: 8'h00};
  int slave_waits = 0;
  int acc_cnt     = 0;

  assign PREADY = PSEL && PENABLE && (acc_cnt >= slave_waits);
  assign PRDATA = PREADY ? smem[PADDR] : ~smem[PADDR];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
  end

  logic [7:0] model_mem [256] = '{default: 8'h00};
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         waits;
    int         lat;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int wt,
                         output int lat, output logic [7:0] rd, output logic er, output logic ok);
    @(negedge PCLK);
    slave_waits = wt;
    ok = req_ready && !busy;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge PCLK);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (!PSEL || PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) ok = 1'b0;
      @(negedge PCLK);
      lat++;
    end
    if (busy || PSEL) ok = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] rd;
    logic       er;
    logic       ok;
    int         nrsp;
    int         idx;
    logic       pend;
    int         psel_cnt;
    int         pen_low;
    logic       seen;
    logic       dropped;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         wt;
    logic [7:0] exp_rd;

    tbl[0] = '{1'b1, 8'h10, 8'hA5, 1, 4, 8'h00};
    tbl[1] = '{1'b0, 8'h10, 8'h00, 1, 4, 8'hA5};
    tbl[2] = '{1'b1, 8'h20, 8'h3C, 0, 3, 8'hA5};
    tbl[3] = '{1'b0, 8'h20, 8'h00, 3, 6, 8'h3C};
    tbl[4] = '{1'b0, 8'h10, 8'h00, 0, 3, 8'hA5};
    tbl[5] = '{1'b1, 8'hFF, 8'h5A, 2, 5, 8'hA5};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1, 4, 8'h00};
    tbl[7] = '{1'b0, 8'hFF, 8'h00, 0, 3, 8'h5A};

    PRST = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    #1;
    chk("reset_ctrl", {PSEL, PENABLE, PWRITE, busy, rsp_valid, rsp_err, req_ready}, 7'b0000001);
    chk("reset_paddr", PADDR, 8'h00);
    chk("reset_pwdata", PWDATA, 8'h00);
    chk("reset_rdata", rsp_rdata, 8'h00);
    repeat (2) @(negedge PCLK);
    PRST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, lat, rd, er, ok);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), er, 1'b0);
      chk($sformatf("tbl%0d_apb", i), ok, 1'b1);
      if (tbl[i].w) model_mem[tbl[i].a] = tbl[i].d;
      model_rdata = tbl[i].rd;
    end

    // Back-to-back writes with req_valid held: PSEL must stay up across all three.
    slave_waits = 0;
    idx = 0; nrsp = 0; psel_cnt = 0; pen_low = 0; seen = 1'b0; dropped = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h01; req_wdata = 8'h11;
    for (int c = 0; c < 40 && nrsp < 3; c++) begin
      pend = req_valid && req_ready;
      @(negedge PCLK);
      if (rsp_valid) nrsp++;
      if (PSEL) begin
        psel_cnt++;
        if (!PENABLE) pen_low++;
        seen = 1'b1;
      end else if (seen && nrsp < 3) begin
        dropped = 1'b1;
      end
      if (pend) begin
        idx++;
        if (idx < 3) begin
          req_addr  = 8'(idx + 1);
          req_wdata = 8'(8'h11 * (idx + 1));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_responses", nrsp, 3);
    chk("b2b_psel_cycles", psel_cnt, 6);
    chk("b2b_penable_low", pen_low, 3);
    chk("b2b_psel_drop", dropped, 1'b0);
    chk("b2b_mem1", smem[1], 8'h11);
    chk("b2b_mem2", smem[2], 8'h22);
    chk("b2b_mem3", smem[3], 8'h33);
    chk("b2b_rdata_kept", rsp_rdata, model_rdata);
    model_mem[1] = 8'h11; model_mem[2] = 8'h22; model_mem[3] = 8'h33;

`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer(1'b0, 8'h20, 8'h00, 100000, lat, rd, er, ok);
    chk("timeout_latency", lat, 6);
    chk("timeout_err", er, 1'b1);
    chk("timeout_rdata_kept", rd, model_rdata);
    chk("timeout_idle", {busy, PSEL, PENABLE}, 3'b000);
`else
    @(negedge PCLK);
    slave_waits = 100000;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
    @(negedge PCLK);
    req_valid = 1'b0;
    nrsp = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (rsp_valid) nrsp++;
    end
    chk("no_timeout_rsp", nrsp, 0);
    chk("no_timeout_access", {busy, PSEL, PENABLE}, 3'b111);
    PRST = 1'b1;
    @(negedge PCLK);
    PRST = 1'b0;
    model_rdata = 8'h00;
`endif

    // Asynchronous reset in the middle of a read's ACCESS phase.
    @(negedge PCLK);
    slave_waits = 3;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_wdata = 8'h77;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    #2 PRST = 1'b1;
    #1;
    chk("rst_mid_ctrl", {PSEL, PENABLE, PWRITE, busy, rsp_valid, rsp_err}, 6'b000000);
    chk("rst_mid_paddr", PADDR, 8'h00);
    chk("rst_mid_pwdata", PWDATA, 8'h00);
    chk("rst_mid_rdata", rsp_rdata, 8'h00);
    nrsp = 0;
    repeat (2) begin
      @(negedge PCLK);
      if (rsp_valid) nrsp++;
    end
    PRST = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      if (rsp_valid) nrsp++;
    end
    chk("rst_mid_no_rsp", nrsp, 0);
    model_rdata = 8'h00;
    do_xfer(1'b0, 8'h10, 8'h00, 1, lat, rd, er, ok);
    chk("rst_recover_latency", lat, 4);
    chk("rst_recover_rdata", rd, 8'hA5);
    chk("rst_recover_apb", ok, 1'b1);
    model_rdata = 8'hA5;

    // Random traffic against the memory/latency model.
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      wt = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
      do_xfer(w, a, d, wt, lat, rd, er, ok);
      if (w) begin
        model_mem[a] = d;
        exp_rd = model_rdata;
      end else begin
        exp_rd = model_mem[a];
        model_rdata = exp_rd;
      end
      chk($sformatf("rnd%0d_latency", i), lat, 3 + wt);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), er, 1'b0);
      chk($sformatf("rnd%0d_apb", i), ok, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
